z80_bus_arbiter: RTL and testbench
==================================

Name: z80_bus_arbiter

Overview:
- Shares the Z80 external bus between the CPU core and one external DMA requester.
- Drives the core's busrq_n and watches busak_n.
- Grants the bus to the DMA master in bounded bursts. Enforces a minimum CPU run window between bursts.
- Aborts a request when the core never acknowledges it.
- Sits beside the tv80s-based z80 core, same clock and clock enable.

Parameters:
- BURST_MAX, 16: maximum cen-qualified cycles dma_gnt stays high per grant (>=1).
- CPU_MIN, 8: minimum cen-qualified cycles the CPU owns the bus after a release before the next request (>=0).
- ACK_TIMEOUT, 64: cycles spent in REQ without busak_n low before the request is abandoned (>=1).
- CNT_W, 8: width of internal counters; must hold max(BURST_MAX, CPU_MIN, ACK_TIMEOUT).

Ports:
- clk  in  1  system clock, shared with the core
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable; state advances only when high
- dma_req  in  1  level request from the DMA master; held while the master wants the bus
- dma_done  in  1  one-cycle pulse from the master: burst finished early
- busak_n  in  1  bus acknowledge from the core, same clock domain, active low
- busrq_n  out  1  bus request to the core, active low, registered
- dma_gnt  out  1  DMA master may drive A/data/control, registered
- ack_err  out  1  one-cycle pulse: request abandoned on timeout
- arb_state  out  2  current FSM state, for debug/status

Behaviour:
- Reset (asynchronous, immediate):
  - state=CPU, busrq_n=1, dma_gnt=0, ack_err=0.
  - cpu_cnt=0, so the first request is not held off. ack_cnt=0, burst_cnt=0.
- cen=0: all registers hold, outputs unchanged, inputs ignored.
- All transitions below happen on a clk rising edge with cen=1. All outputs are registered.
- State encoding: CPU=0, REQ=1, DMA=2, REL=3.
- CPU state (busrq_n=1, dma_gnt=0):
  - cpu_cnt decrements, saturating at 0.
  - If dma_req=1 and cpu_cnt==0: go to REQ, busrq_n=0 from this edge, ack_cnt=0.
  - Request-to-busrq latency is 1 cycle.
- REQ state (busrq_n=0, dma_gnt=0): ack_cnt increments. Priority order:
  - dma_req=0 (cancel): go to REL. This holds even when busak_n=0 in the same cycle; no grant is issued.
  - busak_n=0: go to DMA, dma_gnt=1 from this edge, burst_cnt=0.
  - ack_cnt==ACK_TIMEOUT-1: go to REL, ack_err=1 for exactly one cycle.
- DMA state (busrq_n=0, dma_gnt=1): burst_cnt increments. Exit to REL (dma_gnt=0, busrq_n=1 from that edge) when any of:
  - dma_done=1
  - dma_req=0
  - burst_cnt==BURST_MAX-1
- Grant length: dma_gnt is high for between 1 and BURST_MAX consecutive enabled cycles.
- busak_n rising while in DMA (core protocol violation): go to REL immediately, dma_gnt=0.
- REL state (busrq_n=1, dma_gnt=0):
  - Wait for busak_n=1, then go to CPU and load cpu_cnt=CPU_MIN.
  - dma_req is ignored until CPU state.
  - A late acknowledge after a timeout is absorbed here.
- Invariants checked by the bench:
  - dma_gnt=1 implies busrq_n=0 and busak_n was 0 on the previous enabled edge.
  - dma_gnt and busrq_n=1 are never true together.
  - ack_err is never high in two consecutive cycles.
- CPU_MIN=0: back-to-back requests allowed; CPU gets only the REL handshake cycles.
- Counters never wrap: each is cleared on entry to the state that uses it.

Decomposition:
- Shared package z80_arb_pkg holds:
  - state encoding constants (CPU, REQ, DMA, REL)
  - default BURST_MAX, CPU_MIN, ACK_TIMEOUT values
- No sub-module. The FSM and three counters live in one module; the counters are mutually exclusive by state and may share one register.

Test Plan:
- Basic grant (CPU_MIN=8, BURST_MAX=16):
  - After reset, raise dma_req; core drops busak_n 3 cycles after busrq_n.
  - Required: busrq_n low 1 cycle after dma_req; dma_gnt high 1 cycle after busak_n low.
  - Hold dma_req: dma_gnt high exactly 16 cycles, then busrq_n=1.
- Early done and CPU window:
  - Pulse dma_done on the 5th granted cycle; the core raises busak_n 2 cycles later.
  - Required: dma_gnt high exactly 5 cycles.
  - With dma_req still high, busrq_n must not fall until 8 enabled cycles after state returns to CPU.
- Timeout (ACK_TIMEOUT=64):
  - busak_n held high.
  - Required: ack_err single pulse 64 cycles after busrq_n falls; busrq_n=1; dma_gnt never asserted; state REL then CPU.
- Cancel race:
  - Drop dma_req in the same cycle busak_n falls in REQ.
  - Required: dma_gnt stays 0, busrq_n returns to 1, FSM waits in REL until busak_n=1.
- Clock enable:
  - Toggle cen 1-of-3 during DMA with BURST_MAX=4.
  - Required: dma_gnt high for exactly 4 enabled edges (12 clocks).
  - Outputs frozen while cen=0.
- Async reset mid-burst:
  - Assert rst between edges during DMA.
  - Required: busrq_n=1, dma_gnt=0 immediately, without waiting for clk.
  - arb_state=0; the next request is served without a CPU_MIN holdoff.

Source files
------------

// File: rtl/z80_arb_pkg.sv
// Shared definitions for the Z80 bus arbiter.
// State encoding and default timing parameters.
package z80_arb_pkg;

  typedef enum logic [1:0] {
    CPU = 2'd0,
    REQ = 2'd1,
    DMA = 2'd2,
    REL = 2'd3
  } arb_state_t;

  localparam int BURST_MAX_DEF   = 16;
  localparam int CPU_MIN_DEF     = 8;
  localparam int ACK_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/z80_bus_arbiter.sv
// Shares the Z80 bus between the core and one DMA master.
// Bounded bursts, CPU run window, acknowledge timeout.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int BURST_MAX   = BURST_MAX_DEF,
  parameter int CPU_MIN     = CPU_MIN_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       dma_req,
  input  logic       dma_done,
  input  logic       busak_n,
  output logic       busrq_n,
  output logic       dma_gnt,
  output logic       ack_err,
  output logic [1:0] arb_state
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CPU_LOAD   = CNT_W'(CPU_MIN);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busrq_n_nxt;
  logic             dma_gnt_nxt;
  logic             ack_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CPU;
      cnt     <= '0;
      busrq_n <= 1'b1;
      dma_gnt <= 1'b0;
      ack_err <= 1'b0;
    end else if (cen) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busrq_n <= busrq_n_nxt;
      dma_gnt <= dma_gnt_nxt;
      ack_err <= ack_err_nxt;
    end
  end

  // One counter serves as cpu, ack or burst count depending on state
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ack_err_nxt = 1'b0;
    unique case (state)
      CPU: begin
        if (dma_req && cnt == '0) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end
      end
      REQ: begin
        if (!dma_req) begin
          state_nxt = REL;
        end else if (!busak_n) begin
          state_nxt = DMA;
          cnt_nxt   = '0;
        end else if (cnt == ACK_LAST) begin
          state_nxt   = REL;
          ack_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      DMA: begin
        if (dma_done || !dma_req || busak_n ||
            cnt == BURST_LAST) begin
          state_nxt = REL;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      REL: begin
        if (busak_n) begin
          state_nxt = CPU;
          cnt_nxt   = CPU_LOAD;
        end
      end
      default: state_nxt = CPU;
    endcase
    busrq_n_nxt = (state_nxt == CPU) || (state_nxt == REL);
    dma_gnt_nxt = (state_nxt == DMA);
  end

  assign arb_state = state;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: directed scenarios plus random
// traffic against a behavioural reference, on two configurations.
module tb_z80_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       dma_req = 1'b0;
  logic       dma_done = 1'b0;
  logic       busak_n = 1'b1;
  logic       busrq_n0, dma_gnt0, ack_err0;
  logic       busrq_n1, dma_gnt1, ack_err1;
  logic [1:0] arb_state0, arb_state1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  z80_bus_arbiter u_dut0 (
    .clk(clk), .rst(rst), .cen(cen),
    .dma_req(dma_req), .dma_done(dma_done),
    .busak_n(busak_n), .busrq_n(busrq_n0),
    .dma_gnt(dma_gnt0), .ack_err(ack_err0),
    .arb_state(arb_state0)
  );

  z80_bus_arbiter #(
    .BURST_MAX(4), .CPU_MIN(2), .ACK_TIMEOUT(8), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .cen(cen),
    .dma_req(dma_req), .dma_done(dma_done),
    .busak_n(busak_n), .busrq_n(busrq_n1),
    .dma_gnt(dma_gnt1), .ack_err(ack_err1),
    .arb_state(arb_state1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: state names plus one named counter per rule
  typedef struct {
    int st;
    int cpu_cnt;
    int ack_cnt;
    int burst_cnt;
    bit rq_n;
    bit gnt;
    bit err;
  } ref_t;

  function automatic ref_t ref_rst();
    ref_t m;
    m.st = 0; m.cpu_cnt = 0; m.ack_cnt = 0; m.burst_cnt = 0;
    m.rq_n = 1'b1; m.gnt = 1'b0; m.err = 1'b0;
    return m;
  endfunction

  function automatic ref_t ref_step(ref_t m, int bmax, int cmin,
                                    int tmo, bit req, bit done,
                                    bit ak_n);
    ref_t n = m;
    n.err = 1'b0;
    case (m.st)
      0: if (req && m.cpu_cnt == 0) begin
           n.st = 1; n.ack_cnt = 0;
         end else if (m.cpu_cnt > 0) n.cpu_cnt = m.cpu_cnt - 1;
      1: if (!req) n.st = 3;
         else if (!ak_n) begin n.st = 2; n.burst_cnt = 0; end
         else if (m.ack_cnt == tmo - 1) begin n.st = 3; n.err = 1'b1; end
         else n.ack_cnt = m.ack_cnt + 1;
      2: if (done || !req || ak_n || m.burst_cnt == bmax - 1) n.st = 3;
         else n.burst_cnt = m.burst_cnt + 1;
      default: if (ak_n) begin n.st = 0; n.cpu_cnt = cmin; end
    endcase
    n.rq_n = (n.st == 0) || (n.st == 3);
    n.gnt  = (n.st == 2);
    return n;
  endfunction

  ref_t m0, m1;
  bit   en_edge, ak_last, err_prev0, err_prev1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = ref_rst(); m1 = ref_rst();
      en_edge = 1'b0; ak_last = 1'b1;
      err_prev0 = 1'b0; err_prev1 = 1'b0;
    end else begin
      en_edge = cen;
      if (cen) begin
        err_prev0 = ack_err0;
        err_prev1 = ack_err1;
        ak_last = busak_n;
        m0 = ref_step(m0, 16, 8, 64, dma_req, dma_done, busak_n);
        m1 = ref_step(m1, 4, 2, 8, dma_req, dma_done, busak_n);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rq0", busrq_n0, m0.rq_n);
      chk("m_gnt0", dma_gnt0, m0.gnt);
      chk("m_err0", ack_err0, m0.err);
      chk("m_st0", arb_state0, m0.st);
      chk("m_rq1", busrq_n1, m1.rq_n);
      chk("m_gnt1", dma_gnt1, m1.gnt);
      chk("m_err1", ack_err1, m1.err);
      chk("m_st1", arb_state1, m1.st);
      chk("inv_gntrq0", dma_gnt0 & busrq_n0, 0);
      chk("inv_gntrq1", dma_gnt1 & busrq_n1, 0);
      if (dma_gnt0 || dma_gnt1) chk("inv_ak", ak_last, 0);
      if (en_edge) begin
        chk("inv_err0", err_prev0 & ack_err0, 0);
        chk("inv_err1", err_prev1 & ack_err1, 0);
      end
    end
  end

  initial begin
    int n;
    int k;
    bit saw_gnt;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_st", arb_state0, 0);
    chk("rst_rq", busrq_n0, 1);
    chk("rst_gnt", dma_gnt0, 0);
    chk("rst_err", ack_err0, 0);

    // basic grant, held request
    dma_req = 1'b1;
    tick();
    chk("t1_rq_lat", busrq_n0, 0);
    repeat (2) tick();
    busak_n = 1'b0;
    tick();
    chk("t1_gnt_lat", dma_gnt0, 1);
    n = 0;
    while (dma_gnt0 && n < 40) begin n++; tick(); end
    chk("t1_len", n, 16);
    chk("t1_rel", busrq_n0, 1);
    busak_n = 1'b1;

    // early done, then CPU window
    n = 0;
    while (busrq_n0 && n < 30) begin tick(); n++; end
    chk("t2_req", busrq_n0, 0);
    busak_n = 1'b0;
    tick();
    chk("t2_gnt", dma_gnt0, 1);
    n = 0;
    while (dma_gnt0 && n < 40) begin
      n++;
      dma_done = (n == 5);
      tick();
      dma_done = 1'b0;
    end
    chk("t2_len", n, 5);
    tick();
    chk("t2_rel_wait", arb_state0, 3);
    busak_n = 1'b1;
    n = 0;
    while (arb_state0 != 2'd0 && n < 10) begin tick(); n++; end
    chk("t2_cpu", arb_state0, 0);
    k = 0;
    while (busrq_n0 && k < 30) begin tick(); k++; end
    chk("t2_window", k, 9);

    // timeout: core never acknowledges
    n = 0;
    saw_gnt = 1'b0;
    while (!ack_err0 && n < 100) begin
      tick(); n++;
      if (dma_gnt0) saw_gnt = 1'b1;
    end
    chk("t3_delay", n, 64);
    chk("t3_rq", busrq_n0, 1);
    chk("t3_st", arb_state0, 3);
    chk("t3_nognt", saw_gnt, 0);
    tick();
    chk("t3_pulse", ack_err0, 0);
    chk("t3_cpu", arb_state0, 0);
    dma_req = 1'b0;

    // cancel races acknowledge
    repeat (12) tick();
    dma_req = 1'b1;
    n = 0;
    while (busrq_n0 && n < 20) begin tick(); n++; end
    chk("t4_req", busrq_n0, 0);
    dma_req = 1'b0;
    busak_n = 1'b0;
    tick();
    chk("t4_gnt", dma_gnt0, 0);
    chk("t4_rq", busrq_n0, 1);
    chk("t4_st", arb_state0, 3);
    repeat (3) tick();
    chk("t4_hold", arb_state0, 3);
    busak_n = 1'b1;
    tick();
    chk("t4_cpu", arb_state0, 0);

    // clock enable 1-of-3 during a BURST_MAX=4 grant
    repeat (12) tick();
    dma_req = 1'b1;
    n = 0;
    while (busrq_n1 && n < 20) begin tick(); n++; end
    chk("t5_req", busrq_n1, 0);
    busak_n = 1'b0;
    k = 0;
    for (int i = 0; i < 48; i++) begin
      cen = (i % 3 == 0);
      tick();
      if (dma_gnt1) k++;
    end
    chk("t5_len", k, 12);
    cen = 1'b1;
    dma_req = 1'b0;
    busak_n = 1'b1;
    repeat (12) tick();

    // async reset mid-burst
    dma_req = 1'b1;
    n = 0;
    while (busrq_n0 && n < 20) begin tick(); n++; end
    busak_n = 1'b0;
    n = 0;
    while (!dma_gnt0 && n < 10) begin tick(); n++; end
    chk("t6_gnt", dma_gnt0, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rq", busrq_n0, 1);
    chk("t6_gnt0", dma_gnt0, 0);
    chk("t6_st", arb_state0, 0);
    busak_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_nohold", busrq_n0, 0);

    // random traffic with an emulated core
    for (int i = 0; i < 4000; i++) begin
      tick();
      cen = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
      dma_done = ($urandom_range(0, 15) == 0);
      if (!busrq_n0) begin
        if (busak_n && $urandom_range(0, 2) == 0) busak_n = 1'b0;
        else if (!busak_n && $urandom_range(0, 49) == 0) busak_n = 1'b1;
      end else if (!busak_n && $urandom_range(0, 1) == 0) begin
        busak_n = 1'b1;
      end
    end
    cen = 1'b1;
    dma_done = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
